// File: rtl/basketball_pkg.sv
// Shared definitions for the basketball scoreboard sequencer: FSM encoding,
// scoreboard constants and the game-clock zero compare.
package basketball_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READY     = 3'd1,
    ST_RUN       = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_SHOT_VIOL = 3'd4,
    ST_QTR_END   = 3'd5,
    ST_BREAK     = 3'd6,
    ST_GAME_OVER = 3'd7
  } state_t;

  localparam int SHOT_FULL    = 24;
  localparam int GAME_MINUTES = 12;
  localparam int SECONDS_TOP  = 59;

  function automatic logic clock_zero(input logic [3:0] minutes, input logic [5:0] seconds);
    return (minutes == 4'd0) && (seconds == 6'd0);
  endfunction

endpackage

// File: rtl/buzzer_timer.sv
// Buzzer pulse generator: a load starts a BUZZ_CYCLES-long buzzer level, and
// done flags the final buzzing cycle so the owner can leave on the falling edge.
module buzzer_timer #(
  parameter int BUZZ_CYCLES = 3
) (
  input  logic clock,
  input  logic rst_n,
  input  logic load,
  output logic buzzer,
  output logic done
);

  logic [3:0] cnt_reg;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 4'd0;
    end else if (load) begin
      cnt_reg <= 4'(BUZZ_CYCLES);
    end else if (cnt_reg != 4'd0) begin
      cnt_reg <= cnt_reg - 4'd1;
    end
  end

  assign buzzer = (cnt_reg != 4'd0);
  assign done   = (cnt_reg == 4'd1);

endmodule

// File: rtl/game_period_controller.sv
// Game-flow sequencer driving the scoreboard timer strobes: quarters, breaks,
// halftime, shot-clock violations and the buzzer.
module game_period_controller
  import basketball_pkg::*;
#(
  parameter int NUM_QUARTERS  = 4,
  parameter int BREAK_SECS    = 15,
  parameter int HALFTIME_SECS = 30,
  parameter int BUZZ_CYCLES   = 3
) (
  input  logic       clock,
  input  logic       PB0_n,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic       poss_change_p,
  input  logic       sec_tick,
  input  logic [3:0] minutes,
  input  logic [5:0] seconds,
  input  logic [4:0] shotclock,
  output logic       timer_reset,
  output logic       timer_run,
  output logic       shot_reset,
  output logic       shot_run,
  output logic       buzzer,
  output logic [2:0] quarter,
  output logic [2:0] state,
  output logic [5:0] break_cnt
);

  state_t     state_reg, state_next;
  logic [2:0] quarter_reg, quarter_next;
  logic [5:0] break_reg, break_next;
  logic       timer_reset_reg, timer_reset_next;
  logic       shot_reset_reg, shot_reset_next;
  logic       run_reg, run_next;
  logic       buzz_load, buzz_done;

  buzzer_timer #(.BUZZ_CYCLES(BUZZ_CYCLES)) u_buzzer (
    .clock  (clock),
    .rst_n  (PB0_n),
    .load   (buzz_load),
    .buzzer (buzzer),
    .done   (buzz_done)
  );

  always_ff @(posedge clock or negedge PB0_n) begin
    if (!PB0_n) begin
      state_reg       <= ST_IDLE;
      quarter_reg     <= 3'd1;
      break_reg       <= 6'd0;
      timer_reset_reg <= 1'b0;
      shot_reset_reg  <= 1'b0;
      run_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      quarter_reg     <= quarter_next;
      break_reg       <= break_next;
      timer_reset_reg <= timer_reset_next;
      shot_reset_reg  <= shot_reset_next;
      run_reg         <= run_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    quarter_next     = quarter_reg;
    break_next       = break_reg;
    timer_reset_next = 1'b0;
    shot_reset_next  = 1'b0;
    buzz_load        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start_p) begin
          state_next       = ST_READY;
          timer_reset_next = 1'b1;
          shot_reset_next  = 1'b1;
        end
      end
      ST_READY: begin
        if (start_p) state_next = ST_RUN;
      end
      ST_RUN: begin
        // Status conditions outrank operator pulses in the same cycle.
        if (clock_zero(minutes, seconds)) begin
          state_next = ST_QTR_END;
          buzz_load  = 1'b1;
        end else if (shotclock == 5'd0) begin
          state_next = ST_SHOT_VIOL;
          buzz_load  = 1'b1;
        end else if (pause_p) begin
          state_next = ST_PAUSE;
        end else if (poss_change_p) begin
          shot_reset_next = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (poss_change_p) shot_reset_next = 1'b1;
        if (start_p && !pause_p) state_next = ST_RUN;
      end
      ST_SHOT_VIOL: begin
        if (buzz_done) begin
          state_next      = ST_PAUSE;
          shot_reset_next = 1'b1;
        end
      end
      ST_QTR_END: begin
        if (buzz_done) begin
          if (quarter_reg == 3'(NUM_QUARTERS)) begin
            state_next = ST_GAME_OVER;
          end else begin
            state_next = ST_BREAK;
            break_next = (quarter_reg == 3'(NUM_QUARTERS / 2)) ? 6'(HALFTIME_SECS)
                                                               : 6'(BREAK_SECS);
          end
        end
      end
      ST_BREAK: begin
        if (start_p || break_reg == 6'd0) begin
          state_next       = ST_READY;
          break_next       = 6'd0;
          timer_reset_next = 1'b1;
          shot_reset_next  = 1'b1;
          if (quarter_reg < 3'(NUM_QUARTERS)) quarter_next = quarter_reg + 3'd1;
        end else if (sec_tick) begin
          break_next = break_reg - 6'd1;
        end
      end
      default: ;  // GAME_OVER holds until reset
    endcase

    run_next = (state_next == ST_RUN);
  end

  assign timer_reset = timer_reset_reg;
  assign shot_reset  = shot_reset_reg;
  assign timer_run   = run_reg;
  assign shot_run    = run_reg;
  assign quarter     = quarter_reg;
  assign state       = state_reg;
  assign break_cnt   = break_reg;

endmodule

// File: tb/tb_game_period_controller.sv
// Directed-vector bench for game_period_controller with hand-computed expectations.
module tb_game_period_controller;

  logic       clock = 1'b0;
  logic       PB0_n = 1'b0;
  logic       start_p = 1'b0, pause_p = 1'b0, poss_change_p = 1'b0, sec_tick = 1'b0;
  logic [3:0] minutes = 4'd5;
  logic [5:0] seconds = 6'd30;
  logic [4:0] shotclock = 5'd20;
  logic       timer_reset, timer_run, shot_reset, shot_run, buzzer;
  logic [2:0] quarter, state;
  logic [5:0] break_cnt;

  int checks = 0;
  int errors = 0;

  localparam int IDLE = 0, READY = 1, RUN = 2, PAUSE = 3, SHOT_VIOL = 4,
                 QTR_END = 5, BREAK = 6, GAME_OVER = 7;

  game_period_controller dut (
    .clock(clock), .PB0_n(PB0_n), .start_p(start_p), .pause_p(pause_p),
    .poss_change_p(poss_change_p), .sec_tick(sec_tick), .minutes(minutes),
    .seconds(seconds), .shotclock(shotclock), .timer_reset(timer_reset),
    .timer_run(timer_run), .shot_reset(shot_reset), .shot_run(shot_run),
    .buzzer(buzzer), .quarter(quarter), .state(state), .break_cnt(break_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // From READY: run, hit 0:00, and ride out the buzzer; leaves state after buzzer fall.
  task automatic end_quarter();
    start_p = 1'b1; step(); start_p = 1'b0;
    check("eq_run", state, RUN);
    minutes = 4'd0; seconds = 6'd0;
    step();
    check("eq_qtr_end", state, QTR_END);
    check("eq_buzz_on", buzzer, 1);
    minutes = 4'd5; seconds = 6'd30;
    step(); step();
    check("eq_buzz_last", buzzer, 1);
    step();
    check("eq_buzz_off", buzzer, 0);
  endtask

  initial begin
    #23;
    check("rst_state", state, IDLE);
    check("rst_quarter", quarter, 1);
    check("rst_break", break_cnt, 0);
    check("rst_run", timer_run, 0);
    check("rst_buzz", buzzer, 0);
    @(negedge clock); PB0_n = 1'b1;
    step();

    poss_change_p = 1'b1; step(); poss_change_p = 1'b0;
    check("idle_poss_no_pulse", shot_reset, 0);
    check("idle_poss_state", state, IDLE);

    start_p = 1'b1; step(); start_p = 1'b0;
    check("start_treset", timer_reset, 1);
    check("start_sreset", shot_reset, 1);
    check("start_state", state, READY);
    check("start_quarter", quarter, 1);
    step();
    check("treset_width", timer_reset, 0);
    check("sreset_width", shot_reset, 0);
    check("ready_run", timer_run, 0);

    start_p = 1'b1; step(); start_p = 1'b0;
    check("run_state", state, RUN);
    check("run_trun", timer_run, 1);
    check("run_srun", shot_run, 1);

    start_p = 1'b1; step(); start_p = 1'b0;
    check("run_start_ignored", state, RUN);

    poss_change_p = 1'b1; step(); poss_change_p = 1'b0;
    check("run_poss_pulse", shot_reset, 1);
    check("run_poss_state", state, RUN);
    poss_change_p = 1'b1; step(); poss_change_p = 1'b0;
    check("run_poss_b2b", shot_reset, 1);
    step();
    check("run_poss_end", shot_reset, 0);

    // Shot-clock violation with game clock still running
    shotclock = 5'd0;
    step();
    shotclock = 5'd20;
    check("sv_state", state, SHOT_VIOL);
    check("sv_buzz1", buzzer, 1);
    check("sv_srun", shot_run, 0);
    check("sv_trun", timer_run, 0);
    step();
    check("sv_buzz2", buzzer, 1);
    step();
    check("sv_buzz3", buzzer, 1);
    check("sv_no_sreset_yet", shot_reset, 0);
    step();
    check("sv_buzz_off", buzzer, 0);
    check("sv_pause", state, PAUSE);
    check("sv_sreset", shot_reset, 1);
    step();
    check("sv_sreset_end", shot_reset, 0);

    poss_change_p = 1'b1; step(); poss_change_p = 1'b0;
    check("pause_poss_pulse", shot_reset, 1);
    check("pause_poss_state", state, PAUSE);

    start_p = 1'b1; pause_p = 1'b1; step(); start_p = 1'b0; pause_p = 1'b0;
    check("pause_start_pause", state, PAUSE);

    start_p = 1'b1; step(); start_p = 1'b0;
    check("resume_state", state, RUN);

    // Clock zero beats shotclock zero and pause in the same cycle
    minutes = 4'd0; seconds = 6'd0; shotclock = 5'd0; pause_p = 1'b1;
    step();
    minutes = 4'd5; seconds = 6'd30; shotclock = 5'd20; pause_p = 1'b0;
    check("q1_end_state", state, QTR_END);
    check("q1_end_buzz", buzzer, 1);
    check("q1_end_trun", timer_run, 0);
    step(); step();
    check("q1_buzz3", buzzer, 1);
    step();
    check("q1_break", state, BREAK);
    check("q1_break_cnt", break_cnt, 15);
    check("q1_buzz_off", buzzer, 0);

    start_p = 1'b1; step(); start_p = 1'b0;
    check("skip_state", state, READY);
    check("skip_quarter", quarter, 2);
    check("skip_treset", timer_reset, 1);
    check("skip_break_cnt", break_cnt, 0);

    // Halftime after quarter 2, counted out with sec_tick
    end_quarter();
    check("ht_state", state, BREAK);
    check("ht_break_cnt", break_cnt, 30);
    for (int i = 0; i < 30; i++) begin
      sec_tick = 1'b1; step();
      if (i == 0 || i == 29) check("ht_tick", break_cnt, 29 - i);
    end
    sec_tick = 1'b0;
    check("ht_zero_state", state, BREAK);
    step();
    check("ht_exit_state", state, READY);
    check("ht_exit_quarter", quarter, 3);
    check("ht_exit_treset", timer_reset, 1);
    check("ht_exit_sreset", shot_reset, 1);

    // Quarter 3 break skipped at break_cnt 10
    end_quarter();
    check("q3_break_cnt", break_cnt, 15);
    for (int i = 0; i < 5; i++) begin
      sec_tick = 1'b1; step(); sec_tick = 1'b0; step();
    end
    check("q3_cnt10", break_cnt, 10);
    start_p = 1'b1; step(); start_p = 1'b0;
    check("q3_skip_state", state, READY);
    check("q3_skip_quarter", quarter, 4);

    end_quarter();
    check("go_state", state, GAME_OVER);
    check("go_quarter", quarter, 4);
    start_p = 1'b1; pause_p = 1'b1; step(); start_p = 1'b0; pause_p = 1'b0;
    check("go_ignore", state, GAME_OVER);
    check("go_treset", timer_reset, 0);

    @(negedge clock); PB0_n = 1'b0; #1;
    check("pb0_state", state, IDLE);
    check("pb0_quarter", quarter, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
